sort_buffer_mem: RTL and testbench

//  32x8 working memory for the sort datapath, plus its load and drain stages.

---
 rtl/sort_buffer_mem.sv | 117 +++++++++++
 tb/tb_sort_buffer_mem.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_buffer_mem.sv
// Working memory for the sort datapath: loads one batch over a valid/ready stream,
// lends the array to the datapath while sorting, then drains it in address order.
module sort_buffer_mem #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              load_done,
  input  logic              dp_rd,
  input  logic              dp_wr,
  input  logic [ADDR_W-1:0] dp_adr,
  input  logic [DATA_W-1:0] dp_wdata,
  output logic [DATA_W-1:0] dp_rdata,
  input  logic              sort_done,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    FETCH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADR  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] FIRST_ADR = '0;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              in_hs;
  logic              out_hs;
  logic              load_last;
  logic              drain_last;

  assign in_ready   = (state == LOAD);
  assign load_done  = (state == SORT);
  assign in_hs      = in_valid & in_ready;
  assign out_hs     = out_valid & out_ready & (state == DRAIN);
  assign load_last  = (wptr == LAST_ADR);
  // rptr has already wrapped to 0 while the final element is on out_data
  assign drain_last = (rptr == FIRST_ADR);

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (in_hs && load_last) state_next = SORT;
      SORT:    if (sort_done) state_next = FETCH;
      FETCH:   state_next = DRAIN;
      DRAIN:   if (out_hs && drain_last) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_next;
  end

  // Array contents survive reset; writes come from the load stream or, in SORT only, the datapath.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (in_hs)
        mem[wptr] <= in_data;
      else if (state == SORT && dp_wr)
        mem[dp_adr] <= dp_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      dp_rdata  <= '0;
    end else begin
      if (in_hs)
        wptr <= wptr + 1'b1;
      case (state)
        SORT: begin
          if (dp_rd)
            dp_rdata <= mem[dp_adr];
          if (sort_done)
            rptr <= '0;
        end
        FETCH: begin
          out_data  <= mem[FIRST_ADR];
          out_valid <= 1'b1;
          rptr      <= ADDR_W'(1);
        end
        DRAIN: begin
          if (out_hs) begin
            if (drain_last) begin
              out_valid <= 1'b0;
              wptr      <= '0;
            end else begin
              out_data <= mem[rptr];
              rptr     <= rptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_buffer_mem.sv
// Self-checking bench for sort_buffer_mem: an array model of the memory predicts
// every drained element and every datapath read.
module tb_sort_buffer_mem;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_ready;
  logic       load_done;
  logic       dp_rd = 1'b0;
  logic       dp_wr = 1'b0;
  logic [4:0] dp_adr = '0;
  logic [7:0] dp_wdata = '0;
  logic [7:0] dp_rdata;
  logic       sort_done = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [7:0] model [32];
  logic [7:0] batch [32];

  sort_buffer_mem #(.DATA_W(8), .ADDR_W(5), .DEPTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .load_done(load_done),
    .dp_rd(dp_rd), .dp_wr(dp_wr), .dp_adr(dp_adr), .dp_wdata(dp_wdata), .dp_rdata(dp_rdata),
    .sort_done(sort_done),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clear_inputs();
    in_valid = 1'b0; dp_rd = 1'b0; dp_wr = 1'b0; sort_done = 1'b0; out_ready = 1'b0;
  endtask

  task automatic fill_descending();
    for (int i = 0; i < 32; i++) batch[i] = 8'(31 - i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) batch[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (load_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_load_done: got %b want 0", load_done); end
    checks++;
    if (dp_rdata !== 8'h00) begin failures++; $display("[TB] FAIL reset_dp_rdata: got %h want 00", dp_rdata); end
    checks++;
    if (out_data !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_data: got %h want 00", out_data); end
  endtask

  // Loads batch[0..n-1]; noise drives datapath writes to address 0 and sort_done, which LOAD must ignore.
  task automatic do_load(input int n, input bit gaps, input bit noise);
    int cnt = 0;
    int cyc = 0;
    while (cnt < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (in_ready !== 1'b1 || load_done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL load_state beat %0d: in_ready=%b load_done=%b want 1/0", cnt, in_ready, load_done);
      end
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = batch[cnt];
      if (noise) begin
        dp_wr     = 1'b1;
        dp_adr    = 5'd0;
        dp_wdata  = 8'hFF;
        dp_rd     = 1'($urandom_range(0, 1));
        sort_done = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      if (in_valid) begin
        model[cnt] = batch[cnt];
        cnt++;
      end
    end
    if (cnt < n) begin
      checks++; failures++;
      $display("[TB] FAIL load_timeout: accepted %0d want %0d", cnt, n);
    end
    @(negedge clk);
    clear_inputs();
    if (n == 32) begin
      checks++;
      if (in_ready !== 1'b0 || load_done !== 1'b1) begin
        failures++;
        $display("[TB] FAIL load_complete: in_ready=%b load_done=%b want 0/1", in_ready, load_done);
      end
    end
  endtask

  // Pulses sort_done with a datapath write in the same cycle, which must still land.
  task automatic do_sort_done();
    logic [4:0] a;
    logic [7:0] d;
    a = 5'($urandom_range(0, 31));
    d = 8'($urandom_range(0, 255));
    @(negedge clk);
    sort_done = 1'b1; dp_wr = 1'b1; dp_adr = a; dp_wdata = d;
    model[a] = d;
    @(negedge clk);
    clear_inputs();
    checks++;
    if (out_valid !== 1'b0 || load_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL fetch_cycle: out_valid=%b load_done=%b want 0/0", out_valid, load_done);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== model[0]) begin
      failures++;
      $display("[TB] FAIL first_out: out_valid=%b out_data=%h want 1/%h", out_valid, out_data, model[0]);
    end
  endtask

  // Drains n elements; toggle gives out_ready 1010..; noise drives in_valid, dp_wr and sort_done.
  task automatic do_drain(input int n, input bit toggle, input bit noise);
    int idx = 0;
    int cyc = 0;
    while (idx < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (out_valid !== 1'b1 || out_data !== model[idx] || in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL drain elem %0d: out_valid=%b out_data=%h in_ready=%b want 1/%h/0",
                 idx, out_valid, out_data, in_ready, model[idx]);
      end
      out_ready = toggle ? (cyc % 2 == 1) : 1'b1;
      if (noise) begin
        in_valid  = 1'b1;
        in_data   = 8'($urandom_range(0, 255));
        dp_wr     = 1'b1;
        dp_adr    = 5'($urandom_range(0, 31));
        dp_wdata  = 8'($urandom_range(0, 255));
        sort_done = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      if (out_ready) idx++;
    end
    if (idx < n) begin
      checks++; failures++;
      $display("[TB] FAIL drain_timeout: drained %0d want %0d", idx, n);
    end
    @(negedge clk);
    clear_inputs();
    if (n == 32) begin
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || load_done !== 1'b0) begin
        failures++;
        $display("[TB] FAIL drain_end: out_valid=%b in_ready=%b load_done=%b want 0/1/0",
                 out_valid, in_ready, load_done);
      end
    end
  endtask

  task automatic test_load_drain();
    fill_descending();
    do_load(32, 1'b0, 1'b0);
    do_sort_done();
    do_drain(32, 1'b0, 1'b0);
  endtask

  task automatic test_datapath();
    logic [7:0] exp_rd;
    logic [7:0] old5;
    fill_descending();
    do_load(32, 1'b0, 1'b0);
    @(negedge clk);
    dp_wr = 1'b1; dp_adr = 5'd3; dp_wdata = 8'hAA;
    model[3] = 8'hAA;
    @(negedge clk);
    dp_wr = 1'b0; dp_rd = 1'b1; dp_adr = 5'd3;
    @(negedge clk);
    checks++;
    if (dp_rdata !== 8'hAA) begin failures++; $display("[TB] FAIL dp_rd_after_wr: got %h want aa", dp_rdata); end
    old5 = model[5];
    dp_rd = 1'b1; dp_wr = 1'b1; dp_adr = 5'd5; dp_wdata = 8'h55;
    model[5] = 8'h55;
    @(negedge clk);
    dp_rd = 1'b0; dp_wr = 1'b0;
    checks++;
    if (dp_rdata !== old5) begin failures++; $display("[TB] FAIL dp_same_cycle_old: got %h want %h", dp_rdata, old5); end
    @(negedge clk);
    checks++;
    if (dp_rdata !== old5) begin failures++; $display("[TB] FAIL dp_hold: got %h want %h", dp_rdata, old5); end
    dp_rd = 1'b1; dp_adr = 5'd5;
    @(negedge clk);
    dp_rd = 1'b0;
    checks++;
    if (dp_rdata !== 8'h55) begin failures++; $display("[TB] FAIL dp_rd_new: got %h want 55", dp_rdata); end
    exp_rd = 8'h55;
    for (int i = 0; i < 40; i++) begin
      dp_rd    = 1'($urandom_range(0, 1));
      dp_wr    = 1'($urandom_range(0, 1));
      dp_adr   = 5'($urandom_range(0, 31));
      dp_wdata = 8'($urandom_range(0, 255));
      if (dp_rd) exp_rd = model[dp_adr];
      if (dp_wr) model[dp_adr] = dp_wdata;
      @(negedge clk);
      checks++;
      if (dp_rdata !== exp_rd || load_done !== 1'b1) begin
        failures++;
        $display("[TB] FAIL dp_random %0d: dp_rdata=%h load_done=%b want %h/1", i, dp_rdata, load_done, exp_rd);
      end
    end
    clear_inputs();
    do_sort_done();
    do_drain(32, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    fill_random();
    do_load(32, 1'b1, 1'b0);
    do_sort_done();
    do_drain(32, 1'b1, 1'b0);
  endtask

  task automatic test_illegal();
    fill_random();
    batch[0] = 8'h3C;
    do_load(32, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 255));
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || load_done !== 1'b1) begin
        failures++;
        $display("[TB] FAIL sort_ignores_in: in_ready=%b load_done=%b want 0/1", in_ready, load_done);
      end
      in_valid = 1'b0;
    end
    do_sort_done();
    do_drain(32, 1'b1, 1'b1);
  endtask

  task automatic test_mid_reset();
    fill_random();
    do_load(10, 1'b0, 1'b0);
    test_reset();
    fill_random();
    do_load(32, 1'b1, 1'b0);
    do_sort_done();
    do_drain(7, 1'b1, 1'b0);
    test_reset();
    fill_random();
    do_load(32, 1'b0, 1'b0);
    do_sort_done();
    do_drain(32, 1'b1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_load_drain();
    test_datapath();
    test_backpressure();
    test_illegal();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
